sd_spi_cmd: RTL
===============

# sd_spi_cmd

SPI-mode SD command engine sitting directly downstream of the SD boot sequencer. It generates the SPI clock from the system clock and serialises a 48-bit command frame on MOSI. It then captures the card's R1 response from MISO and reports its 7 status bits back to the sequencer through a start/available/valid_status handshake. Chip select is not driven here; the sequencer owns it.

## Interface
Parameters:
- NCR_MAX, 64, maximum sclk bits to wait for the response start bit before timeout.
- TRAIL_BITS, 8, idle sclk bits with MOSI=1 after each response.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd  in  7  command index; cmd[5:0] used, cmd[6] ignored
- arg  in  32  command argument, latched at accept
- start  in  1  level request; see handshake rules
- en_clk  in  1  sclk enable
- div_clk  in  8  sclk half-period minus one, in clk cycles
- miso  in  1  card data out
- sclk  out  1  SPI clock, registered
- mosi  out  1  card data in, registered
- available  out  1  engine idle and ready
- valid_status  out  1  one-cycle pulse, status valid
- status  out  7  R1[6:0], or 7'h7F on timeout

## Operation
- Divider: counter increments each clk while en_clk=1. When count >= div_clk, sclk toggles and count clears. `>=` makes a div_clk decrease take effect immediately. en_clk=0: sclk forced 0, count cleared, FSM frozen.
- fall_tick / rise_tick: the clk on which sclk goes 1→0 / 0→1. MOSI changes only on fall_tick. MISO is sampled only on rise_tick (SPI mode 0).
- sclk runs freely in IDLE, with MOSI=1, so the sequencer can count init clocks.
- Frame, MSB first: {2'b01, cmd[5:0]}, arg[31:0], {crc, 1'b1}.
- FSM states:
  - IDLE: available=1. Accept when start=1 and armed=1. On accept: latch cmd/arg, clear armed, available=0 next cycle, go to SEND.
  - SEND: the first frame bit is driven on the first fall_tick after accept. 48 bits total. Go to WAIT after bit 47's sclk high phase.
  - WAIT: MOSI=1. Sample MISO on each rise_tick. MISO=0 → RESP. NCR_MAX samples all 1 → status<=7'h7F, pulse valid_status, go to TRAIL.
  - RESP: shift the next 7 sampled bits. After the 7th: status<=bits, pulse valid_status, go to TRAIL.
  - TRAIL: TRAIL_BITS sclk periods with MOSI=1, then IDLE (available=1).
- armed: set when start=0 in any cycle; cleared on accept. After completion, start must be seen low for ≥1 clk before the next accept. Reset sets armed=1.
- status holds its value until the next valid_status.

## Timing
- Reset values: sclk=0, mosi=1, available=1, valid_status=0, status=7'h00, FSM=IDLE, armed=1, divider count=0.
- sclk half-period = div_clk+1 clk cycles. div_clk=0 gives a toggle every clk.
- available falls the clk after accept. It rises on the clk of the final TRAIL fall_tick.
- valid_status is asserted on the clk after the final response rise_tick (or timeout sample). It always precedes the rise of available by TRAIL_BITS sclk periods.
- start asserted while available=0 is ignored, except that it keeps armed cleared.
- rst mid-transaction: all outputs return to reset values on the next clk. No partial valid_status is emitted.

## Configuration
- SD_CRC7_EN defined: CRC7 (x^7+x^3+1, init 0) is computed serially over the first 40 frame bits during SEND. Frame byte 5 = {crc7, 1}.
- SD_CRC7_EN undefined: frame byte 5 = 8'h95 for every command. This is correct only for CMD0, which is acceptable because CRC is off in SPI mode after CMD0.

## Test plan
- Reset, en_clk=1, div_clk=8'hFF → sclk period 512 clk; mosi=1, available=1, valid_status=0, status=7'h00.
- cmd=0, arg=0, start=1; MISO returns 0xFF,0xFF then 0x01 → MOSI carries 40 00 00 00 00 95. A single valid_status pulse with status=7'h01, then available=1 eight sclk periods later.
- start held high across completion → no second frame. Drop start for 1 clk, then reassert → new frame starts on the next fall_tick.
- MISO tied 1 → after 64 WAIT samples, valid_status with status=7'h7F, then TRAIL and IDLE.
- SD_CRC7_EN defined, cmd=8, arg=32'h000001AA → last frame byte 8'h87. Without the macro → 8'h95.
- div_clk=0 → sclk toggles every clk. Assert rst during SEND bit 20 → next clk mosi=1, sclk=0, available=1, no valid_status.

Source files
------------

// File: rtl/sd_spi_cmd.sv
// SPI-mode SD command engine: sclk divider, 48-bit command serialiser, R1 capture.
// Define SD_CRC7_EN to compute CRC7 for byte 5; otherwise the CMD0 CRC byte 8'h95 is sent.
module sd_spi_cmd #(
  parameter int NCR_MAX    = 64,
  parameter int TRAIL_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  cmd,
  input  logic [31:0] arg,
  input  logic        start,
  input  logic        en_clk,
  input  logic [7:0]  div_clk,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        available,
  output logic        valid_status,
  output logic [6:0]  status
);
  localparam int NW = $clog2(NCR_MAX + 1);
  localparam int TW = $clog2(TRAIL_BITS + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RESP, TRAIL} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            avail_q, avail_d;
  logic            valid_q, valid_d;
  logic [6:0]      status_q, status_d;
  logic            armed_q, armed_d;
  logic [39:0]     frame_q, frame_d;
  logic [5:0]      bcnt_q, bcnt_d;
  logic [NW-1:0]   ncnt_q, ncnt_d;
  logic [5:0]      rsh_q, rsh_d;
  logic [2:0]      rcnt_q, rcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [7:0]      tail;
  logic            tick, fall_tick, rise_tick;
  logic            cmd6_unused;

  assign cmd6_unused = cmd[6];

`ifdef SD_CRC7_EN
  logic [6:0] crc_q, crc_d;
  assign tail = {crc_q, 1'b1};
`else
  assign tail = 8'h95;
`endif

  // A div_clk decrease below the running count takes effect at once.
  assign tick      = en_clk && (cnt_q >= div_clk);
  assign fall_tick = tick && sclk_q;
  assign rise_tick = tick && !sclk_q;

  always_comb begin
    cnt_d    = en_clk ? (tick ? 8'd0 : cnt_q + 8'd1) : 8'd0;
    sclk_d   = en_clk ? (tick ? ~sclk_q : sclk_q) : 1'b0;
    state_d  = state_q;
    mosi_d   = mosi_q;
    avail_d  = avail_q;
    valid_d  = 1'b0;
    status_d = status_q;
    armed_d  = start ? armed_q : 1'b1;
    frame_d  = frame_q;
    bcnt_d   = bcnt_q;
    ncnt_d   = ncnt_q;
    rsh_d    = rsh_q;
    rcnt_d   = rcnt_q;
    tcnt_d   = tcnt_q;
`ifdef SD_CRC7_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      IDLE: begin
        mosi_d = 1'b1;
        if (en_clk && start && armed_q) begin
          state_d = SEND;
          frame_d = {2'b01, cmd[5:0], arg};
          bcnt_d  = '0;
          avail_d = 1'b0;
          armed_d = 1'b0;
`ifdef SD_CRC7_EN
          crc_d   = '0;
`endif
        end
      end
      SEND: if (fall_tick) begin
        if (bcnt_q == 6'd48) begin
          mosi_d  = 1'b1;
          ncnt_d  = '0;
          state_d = WAIT;
        end else if (bcnt_q < 6'd40) begin
          mosi_d  = frame_q[39];
          frame_d = {frame_q[38:0], 1'b0};
          bcnt_d  = bcnt_q + 6'd1;
`ifdef SD_CRC7_EN
          crc_d   = {crc_q[5:0], 1'b0} ^ ((crc_q[6] ^ frame_q[39]) ? 7'h09 : 7'h00);
`endif
        end else begin
          mosi_d = tail[~bcnt_q[2:0]];
          bcnt_d = bcnt_q + 6'd1;
        end
      end
      WAIT: if (rise_tick) begin
        if (!miso) begin
          rcnt_d  = '0;
          state_d = RESP;
        end else if (ncnt_q == NW'(NCR_MAX - 1)) begin
          status_d = 7'h7F;
          valid_d  = 1'b1;
          tcnt_d   = '0;
          state_d  = TRAIL;
        end else begin
          ncnt_d = ncnt_q + 1'b1;
        end
      end
      RESP: if (rise_tick) begin
        rsh_d = {rsh_q[4:0], miso};
        if (rcnt_q == 3'd6) begin
          status_d = {rsh_q, miso};
          valid_d  = 1'b1;
          tcnt_d   = '0;
          state_d  = TRAIL;
        end else begin
          rcnt_d = rcnt_q + 3'd1;
        end
      end
      TRAIL: if (fall_tick) begin
        if (tcnt_q == TW'(TRAIL_BITS - 1)) begin
          avail_d = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      avail_q  <= 1'b1;
      valid_q  <= 1'b0;
      status_q <= '0;
      armed_q  <= 1'b1;
      frame_q  <= '0;
      bcnt_q   <= '0;
      ncnt_q   <= '0;
      rsh_q    <= '0;
      rcnt_q   <= '0;
      tcnt_q   <= '0;
`ifdef SD_CRC7_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      avail_q  <= avail_d;
      valid_q  <= valid_d;
      status_q <= status_d;
      armed_q  <= armed_d;
      frame_q  <= frame_d;
      bcnt_q   <= bcnt_d;
      ncnt_q   <= ncnt_d;
      rsh_q    <= rsh_d;
      rcnt_q   <= rcnt_d;
      tcnt_q   <= tcnt_d;
`ifdef SD_CRC7_EN
      crc_q    <= crc_d;
`endif
    end
  end

  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign available    = avail_q;
  assign valid_status = valid_q;
  assign status       = status_q;
endmodule
